// File: rtl/cluster_dispatch_queue.sv
// Purpose: buffers rename bundles into one FIFO per execution cluster, each drained by its own valid/ready issue port.
// Latency: a uop accepted at edge N appears on its issue port after edge N; there is no bypass from rename.
// Backpressure: a bundle is taken whole only if every target FIFO has room at its registered occupancy; pops give no same-cycle credit.
module cluster_dispatch_queue #(
    parameter int MAX_UOPS     = 2,
    parameter int NUM_CLUSTERS = 4,
    parameter int DEPTH        = 4,
    parameter int UOP_W        = 8,
    parameter int CLUSTER_W    = 2,
    parameter int CNT_W        = 16
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        flush_i,
    input  logic                                        rename_valid_i,
    input  logic [MAX_UOPS*UOP_W-1:0]                   rename_uops_i,
    input  logic [MAX_UOPS*CLUSTER_W-1:0]               rename_cluster_i,
    input  logic [$clog2(MAX_UOPS+1)-1:0]               rename_uop_count_i,
    output logic                                        dispatch_ready_o,
    output logic [NUM_CLUSTERS-1:0]                     issue_valid_o,
    output logic [NUM_CLUSTERS*UOP_W-1:0]               issue_uop_o,
    input  logic [NUM_CLUSTERS-1:0]                     issue_ready_i,
    output logic [NUM_CLUSTERS*$clog2(DEPTH+1)-1:0]     occupancy_o,
    output logic [NUM_CLUSTERS*CNT_W-1:0]               issue_count_o
);

    localparam int CNT_IN_W = $clog2(MAX_UOPS + 1);
    localparam int OCC_W    = $clog2(DEPTH + 1);
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CL_IDX_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

    logic [UOP_W-1:0]    mem        [NUM_CLUSTERS][DEPTH];
    logic [PTR_W-1:0]    wr_ptr     [NUM_CLUSTERS];
    logic [PTR_W-1:0]    rd_ptr     [NUM_CLUSTERS];
    logic [PTR_W-1:0]    wr_ptr_nxt [NUM_CLUSTERS];
    logic [OCC_W-1:0]    occ        [NUM_CLUSTERS];
    logic [OCC_W-1:0]    demand     [NUM_CLUSTERS];
    logic [CNT_W-1:0]    cnt        [NUM_CLUSTERS];

    logic [CNT_IN_W-1:0] lane_cnt;
    logic                lane_vld   [MAX_UOPS];
    logic [CL_IDX_W-1:0] lane_cl    [MAX_UOPS];
    logic [OCC_W-1:0]    lane_off   [MAX_UOPS];
    logic [PTR_W-1:0]    lane_idx   [MAX_UOPS];

    logic                    push;
    logic [NUM_CLUSTERS-1:0] pop;

    function automatic int wrap_idx(input int v);
        return (v >= DEPTH) ? v - DEPTH : v;
    endfunction

    // Lane decode: each valid lane gets its rank among earlier lanes to the same cluster.
    always_comb begin
        lane_cnt = rename_uop_count_i;
        if (rename_uop_count_i > CNT_IN_W'(MAX_UOPS)) begin
            lane_cnt = CNT_IN_W'(MAX_UOPS);
        end
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            demand[c] = '0;
        end
        for (int i = 0; i < MAX_UOPS; i++) begin
            lane_vld[i] = CNT_IN_W'(i) < lane_cnt;
            lane_cl[i]  = '0;
            if (int'(rename_cluster_i[i*CLUSTER_W +: CLUSTER_W]) < NUM_CLUSTERS) begin
                lane_cl[i] = CL_IDX_W'(rename_cluster_i[i*CLUSTER_W +: CLUSTER_W]);
            end
            lane_off[i] = '0;
            if (lane_vld[i]) begin
                lane_off[i]         = demand[lane_cl[i]];
                demand[lane_cl[i]]  = demand[lane_cl[i]] + OCC_W'(1);
            end
        end
    end

    always_comb begin
        dispatch_ready_o = !flush_i;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            if ((OCC_W'(DEPTH) - occ[c]) < demand[c]) begin
                dispatch_ready_o = 1'b0;
            end
            wr_ptr_nxt[c] = PTR_W'(wrap_idx(int'(wr_ptr[c]) + int'(demand[c])));
            pop[c]        = (occ[c] != '0) && issue_ready_i[c];
        end
        for (int i = 0; i < MAX_UOPS; i++) begin
            lane_idx[i] = PTR_W'(wrap_idx(int'(wr_ptr[lane_cl[i]]) + int'(lane_off[i])));
        end
    end

    assign push = rename_valid_i && dispatch_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                occ[c]    <= '0;
                cnt[c]    <= '0;
            end
        end else if (flush_i) begin
            // Counters survive a flush; a pop on the flush edge is dropped uncounted.
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                occ[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                if (pop[c]) begin
                    rd_ptr[c] <= (rd_ptr[c] == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr[c] + PTR_W'(1);
                    cnt[c]    <= cnt[c] + CNT_W'(1);
                end
                if (push) begin
                    wr_ptr[c] <= wr_ptr_nxt[c];
                end
                occ[c] <= occ[c] + (push ? demand[c] : '0) - OCC_W'(pop[c]);
            end
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            for (int i = 0; i < MAX_UOPS; i++) begin
                if (lane_vld[i]) begin
                    mem[lane_cl[i]][lane_idx[i]] <= rename_uops_i[i*UOP_W +: UOP_W];
                end
            end
        end
    end

    always_comb begin
        issue_valid_o = '0;
        issue_uop_o   = '0;
        occupancy_o   = '0;
        issue_count_o = '0;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            issue_valid_o[c]                 = occ[c] != '0;
            occupancy_o[c*OCC_W +: OCC_W]    = occ[c];
            issue_count_o[c*CNT_W +: CNT_W]  = cnt[c];
            if (occ[c] != '0) begin
                issue_uop_o[c*UOP_W +: UOP_W] = mem[c][rd_ptr[c]];
            end
        end
    end

endmodule

// File: doc/cluster_dispatch_queue.md
Name: cluster_dispatch_queue

Overview:
Parametrised successor to dispatch_stub. It accepts bundles of up to MAX_UOPS renamed uops per cycle, each tagged with a target cluster, and buffers them in one FIFO per cluster (ALU, CAPABILITY, LSQ, ASYNC by default). Each cluster drains independently through a valid/ready issue port. The block sits between rename and the cluster issue stages, and replaces the stub's single-cycle classification with real buffering, back-pressure, flush and per-cluster issue counters.

Parameters:
MAX_UOPS, 2, uops per rename bundle (lanes); >=1.
NUM_CLUSTERS, 4, cluster count; index encoding as cluster_pkg (0 ALU, 1 CAPABILITY, 2 LSQ, 3 ASYNC).
DEPTH, 4, entries per cluster FIFO; must be >= MAX_UOPS; need not be a power of two.
UOP_W, 8, uop tag width; instantiate with $bits(uop_pkg::uop_tag_t).
CLUSTER_W, 2, cluster index width; must satisfy 2**CLUSTER_W >= NUM_CLUSTERS.
CNT_W, 16, issue counter width.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
flush_i  in  1  synchronous flush of all FIFOs.
rename_valid_i  in  1  bundle valid.
rename_uops_i  in  MAX_UOPS*UOP_W  lane i at [i*UOP_W +: UOP_W].
rename_cluster_i  in  MAX_UOPS*CLUSTER_W  target cluster per lane.
rename_uop_count_i  in  $clog2(MAX_UOPS+1)  number of valid lanes, lanes 0..count-1.
dispatch_ready_o  out  1  bundle can be accepted this cycle.
issue_valid_o  out  NUM_CLUSTERS  per-cluster FIFO head valid.
issue_uop_o  out  NUM_CLUSTERS*UOP_W  per-cluster head uop.
issue_ready_i  in  NUM_CLUSTERS  per-cluster consumer ready.
occupancy_o  out  NUM_CLUSTERS*$clog2(DEPTH+1)  per-cluster entry count.
issue_count_o  out  NUM_CLUSTERS*CNT_W  per-cluster issued-uop counter.

Behaviour:
- Reset (rst_ni low, async): all FIFOs empty; pointers, occupancy and counters 0; issue_valid_o = 0; issue_uop_o = 0.
- Lane validity: lane i is valid when i < min(rename_uop_count_i, MAX_UOPS). Counts above MAX_UOPS clamp to MAX_UOPS.
- Out-of-range clusters: a cluster index >= NUM_CLUSTERS routes to cluster 0.
- Demand: per cluster c, demand[c] = number of valid lanes targeting c.
- dispatch_ready_o = !flush_i AND, for every c, (DEPTH - occupancy[c]) >= demand[c].
  - Occupancy is the registered value. Same-cycle pops grant no extra credit.
  - dispatch_ready_o has a combinational path from rename_cluster_i and rename_uop_count_i, but must not depend on rename_valid_i.
- Accept: rename_valid_i && dispatch_ready_o at a rising edge.
  - Acceptance is all-or-nothing: no partial bundle is ever enqueued.
  - Lanes targeting the same cluster enqueue in ascending lane order.
  - Count 0 is accepted and has no effect.
- Issue: issue_valid_o[c] = occupancy[c] != 0, and issue_uop_o[c] is the FIFO head. Both are driven from registers or storage, with no combinational path from the inputs.
- Pop: issue_valid_o[c] && issue_ready_i[c] at an edge removes the head.
- Latency: a uop accepted at edge N is visible on its issue port after edge N (earliest pop at edge N+1). There is no same-cycle bypass from the rename inputs.
- Simultaneous push and pop: both occur in the same cycle; occupancy[c] becomes occupancy + pushes - pop. A full FIFO with a pop still refuses a push that cycle (no credit).
- Pointer wrap: read and write pointers wrap from DEPTH-1 to 0.
- Flush: flush_i high at an edge empties all FIFOs (occupancy 0).
  - Flush has priority over same-edge push and pop.
  - A pop coincident with flush is not counted.
  - Counters are preserved across flush.
- Counters: issue_count_o[c] increments by 1 per pop and wraps modulo 2**CNT_W.
- Reset mid-operation: immediate return to reset state; buffered uops are discarded.

Test Plan:
- Reset, then one bundle {uop 0x12 -> cluster 1, uop 0x34 -> cluster 1}, count 2 -> after the edge, occupancy[1]=2 and issue_uop_o[1]=0x12. Pop twice: 0x34 follows, issue_count_o[1]=2.
- issue_ready_i=0; push 4 single uops to ALU (DEPTH=4) -> dispatch_ready_o=0 for a further ALU uop, but =1 for a bundle with count 1 to LSQ. A bundle {ALU, LSQ} is refused whole, with LSQ occupancy unchanged.
- ALU full with issue_ready_i[0]=1 and an ALU push offered -> push refused that cycle, pop counted, occupancy 3. Next cycle the push is accepted.
- Push 3 uops into ASYNC, then assert flush_i together with issue_ready_i[3]=1 -> occupancy all 0, issue_count_o[3] unchanged, dispatch_ready_o=0 while flush_i is high.
- Stream 10 uops through LSQ with issue_ready_i=1 -> FIFO order preserved across pointer wrap, issue_count_o[2]=10, first issue visible one cycle after acceptance.
- rename_uop_count_i=3 with MAX_UOPS=2, and lane cluster=7 with NUM_CLUSTERS=4 and CLUSTER_W=3 -> 2 lanes accepted, and the out-of-range lane lands in ALU.
